i2c_gain_regbank: RTL

//  Parametrised register bank between the I2C slave front-end and the PID datapath.

---
 rtl/i2c_gain_regbank.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_gain_regbank.sv
// i2c_gain_regbank
//   Byte-wide register bank sitting between the I2C slave front-end and the
//   PID datapath. Writes land in shadow registers. A commit copies every
//   shadow register into the active set in a single cycle, so the PID core
//   never sees a half-updated gain set. An address pointer auto-increments
//   after each access so that bursts need only one address phase.
//
//   Optional build macro: REGBANK_LOCK_EN
//     defined   -> a lock register (bit 0 only) is placed at
//                  BASE_ADDR+NUM_REGS. While it is set, gain writes are
//                  dropped with err and commit is ignored.
//     undefined -> no lock register; that address is out of range.
module i2c_gain_regbank #(
  parameter int         NUM_REGS  = 4,
  parameter int         DATA_W    = 6,
  parameter int         BUS_W     = 8,
  parameter logic [7:0] BASE_ADDR = 8'h40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       addr_load,
  input  logic [7:0]                 reg_addr,
  input  logic                       wr_valid,
  input  logic [BUS_W-1:0]           wr_data,
  input  logic                       rd_req,
  input  logic                       commit,
  output logic [BUS_W-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       err,
  output logic [NUM_REGS*DATA_W-1:0] gains
);

  localparam int GAIN_LO = int'(BASE_ADDR);

`ifdef REGBANK_LOCK_EN
  // The lock register is the final address the pointer visits before wrapping.
  localparam logic [7:0] LOCK_ADDR = 8'(GAIN_LO + NUM_REGS);
  localparam logic [7:0] TOP_ADDR  = LOCK_ADDR;
`else
  localparam logic [7:0] TOP_ADDR  = 8'(GAIN_LO + NUM_REGS - 1);
`endif

  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] active [NUM_REGS];
  logic [7:0]        ptr;

  logic [7:0]          eff;
  logic [7:0]          ptr_next;
  logic [NUM_REGS-1:0] gain_hit;
  logic [DATA_W-1:0]   rd_gain;
  logic                gain_sel;
  logic                lock_hit;
  logic                locked;
  logic                in_range;
  logic                collide;
  logic                do_wr;
  logic                do_rd;
  logic                access;
  logic                wr_store;
  logic                wr_err;

  // Address decode: effective address, per-register hit and read-mux value.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    eff      = addr_load ? reg_addr : ptr;
    gain_hit = '0;
    rd_gain  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      gain_hit[i] = (eff == 8'(GAIN_LO + i));
      if (gain_hit[i]) begin
        rd_gain = shadow[i];
      end
    end
    gain_sel = |gain_hit;
  end

`ifdef REGBANK_LOCK_EN
  logic lock_q;

  assign lock_hit = (eff == LOCK_ADDR);
  assign locked   = lock_q;

  // Lock register: only bit 0 of the bus is kept; it is writable even while set so it can be cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (do_wr && lock_hit) begin
      lock_q <= wr_data[0];
    end
  end
`else
  assign lock_hit = 1'b0;
  assign locked   = 1'b0;
`endif

  // Request qualification: classify this cycle's strobes into a write, a read or a collision.
  always_comb begin
    in_range = gain_sel | lock_hit;
    collide  = ena & wr_valid & rd_req;
    do_wr    = ena & wr_valid & ~rd_req;
    do_rd    = ena & rd_req & ~wr_valid;
    access   = do_wr | do_rd;
    wr_store = do_wr & gain_sel & ~locked;
    wr_err   = do_wr & (~in_range | (gain_sel & locked));
  end

  // Next pointer after an access: stick on a bad address, wrap after the top address, else step by one.
  always_comb begin
    ptr_next = eff;
    if (in_range) begin
      ptr_next = (eff == TOP_ADDR) ? BASE_ADDR : eff + 8'd1;
    end
  end

  // Address pointer: advances on an access, loads on a bare addr_load, holds on a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= BASE_ADDR;
    end else if (access) begin
      ptr <= ptr_next;
    end else if (ena && addr_load && !collide) begin
      ptr <= reg_addr;
    end
  end

  // Shadow registers: the target of bus writes; only the low DATA_W bits are stored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: these small register arrays are reset explicitly, since the PID core must start from zero gains; a RAM would not be.
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
    end else if (wr_store) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (gain_hit[i]) begin
          shadow[i] <= wr_data[DATA_W-1:0];
        end
      end
    end
  end

  // Active registers: copied from shadow as one atomic set on commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active[i] <= '0;
      end
    end else if (ena && commit && !locked) begin
      // NOTE: non-blocking assignment means a same-cycle write is not yet visible here, so commit copies the pre-write shadow.
      for (int i = 0; i < NUM_REGS; i++) begin
        active[i] <= shadow[i];
      end
    end
  end

  // Registered read data and the one-cycle rd_valid / err pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      err      <= wr_err | collide | (do_rd & ~in_range);
      if (do_rd) begin
        if (gain_sel) begin
          rd_data <= BUS_W'(rd_gain);
        end else if (lock_hit) begin
          rd_data <= BUS_W'(locked);
        end else begin
          rd_data <= '0;
        end
      end
    end
  end

  // Flatten the active set onto the gains bus, index i at [i*DATA_W +: DATA_W].
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_gains
    assign gains[g*DATA_W +: DATA_W] = active[g];
  end

  // Bus bits above DATA_W are discarded on writes.
  if (BUS_W > DATA_W) begin : g_wr_upper
    logic unused_wr_upper;
    assign unused_wr_upper = ^wr_data[BUS_W-1:DATA_W];
  end

endmodule
